// File: rtl/dma_w_burst_split.sv
// ---------------------------------------------------------------------------
// dma_w_burst_split
//   Upstream feeder for the DMA AXI write engine. A job (base address, word
//   count) is split into INCR bursts of at most MAX_BURST beats that never
//   cross a 4 KB boundary. Stream words are buffered in a first-word-fall-
//   through FIFO, and a burst is only offered once the FIFO holds all of its
//   beats, so the engine is never starved mid-burst.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle job launch pulse (ignored while busy)
//   base_addr           job byte address (sub-word bits dropped on capture)
//   word_count          job length in words (0 -> immediate done)
//   busy, done          job in progress / one-cycle end-of-job pulse
//   s_valid, s_data     input word stream
//   s_ready             stream word accepted when s_valid && s_ready
//   valid               burst request to the write engine
//   addr, dma_len       burst start address / beats-1, stable while valid
//   wdata, wstrb        FIFO head word / all-ones byte strobes
//   ready               one pulse per beat consumed (pops the FIFO)
//   dma_ready           write engine idle (address-handshake state)
// ---------------------------------------------------------------------------
module dma_w_burst_split #(
    parameter int DMA_DATA_W  = 32,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 8,
    parameter int FIFO_ADDR_W = 4,
    parameter int MAX_BURST   = 16,
    parameter int CNT_W       = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [CNT_W-1:0]        word_count,
    output logic                    busy,
    output logic                    done,
    input  logic                    s_valid,
    input  logic [DMA_DATA_W-1:0]   s_data,
    output logic                    s_ready,
    output logic                    valid,
    output logic [ADDR_W-1:0]       addr,
    output logic [DMA_DATA_W-1:0]   wdata,
    output logic [DMA_DATA_W/8-1:0] wstrb,
    output logic [LEN_W-1:0]        dma_len,
    input  logic                    ready,
    input  logic                    dma_ready
);

    localparam int BYTES  = DMA_DATA_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int DEPTH  = 1 << FIFO_ADDR_W;
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    // Common width for the three-way minimum (to_4k needs 13 bits).
    localparam int MIN_W  = (CNT_W > 13) ? CNT_W : 13;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_WAIT_DATA,
        ST_BURST,
        ST_WAIT_IDLE
    } state_t;

    state_t                   state_r;
    state_t                   state_s;

    logic [DMA_DATA_W-1:0]    mem_r [DEPTH];
    logic [FIFO_ADDR_W-1:0]   wr_ptr_r;
    logic [FIFO_ADDR_W-1:0]   rd_ptr_r;
    logic [FIFO_ADDR_W:0]     level_r;
    logic                     push_s;
    logic                     pop_s;
    logic                     fifo_full_s;
    logic                     fifo_enough_s;

    logic                     busy_r;
    logic                     done_r;
    logic                     valid_r;
    logic [ADDR_W-1:0]        addr_r;
    logic [LEN_W-1:0]         dma_len_r;
    logic [CNT_W-1:0]         job_cnt_r;
    logic [CNT_W-1:0]         in_cnt_r;
    logic [CNT_W-1:0]         remaining_r;
    logic [ADDR_W-1:0]        cur_addr_r;
    logic [BEAT_W-1:0]        beats_r;
    logic [BEAT_W-1:0]        beat_cnt_r;

    logic [12:0]              to_4k_s;
    logic [MIN_W-1:0]         lim_s;
    logic [MIN_W-1:0]         min_s;
    logic [BEAT_W-1:0]        beats_s;
    logic                     last_beat_s;

    // ---------------- FIFO ----------------
    assign fifo_full_s   = (level_r == (FIFO_ADDR_W+1)'(DEPTH));
    assign s_ready       = busy_r && !fifo_full_s && (in_cnt_r != job_cnt_r);
    assign push_s        = s_valid && s_ready;
    // A pop on an empty FIFO is a protocol error and is dropped.
    assign pop_s         = ready && (level_r != {(FIFO_ADDR_W+1){1'b0}});
    assign fifo_enough_s = (level_r >= (FIFO_ADDR_W+1)'(beats_r));
    assign wdata         = mem_r[rd_ptr_r];

    // FIFO storage array (no reset; validity is tracked by the pointers).
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s_data;
        end
    end

    // FIFO pointers and fill level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {FIFO_ADDR_W{1'b0}};
            rd_ptr_r <= {FIFO_ADDR_W{1'b0}};
            level_r  <= {(FIFO_ADDR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_ADDR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_ADDR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + (FIFO_ADDR_W+1)'(1);
                2'b01:   level_r <= level_r - (FIFO_ADDR_W+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // ---------------- burst sizing ----------------
    // Words left before the next 4 KB boundary; 1024 at an aligned page start.
    assign to_4k_s     = (13'd4096 - {1'b0, cur_addr_r[11:0]}) >> OFF_W;
    assign lim_s       = (MIN_W'(MAX_BURST) < MIN_W'(to_4k_s)) ? MIN_W'(MAX_BURST)
                                                               : MIN_W'(to_4k_s);
    assign min_s       = (MIN_W'(remaining_r) < lim_s) ? MIN_W'(remaining_r) : lim_s;
    assign beats_s     = BEAT_W'(min_s);
    assign last_beat_s = ready && ((beat_cnt_r + BEAT_W'(1)) == beats_r);

    // ---------------- FSM ----------------
    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && (word_count != {CNT_W{1'b0}})) state_s = ST_CALC;
                else                                        state_s = ST_IDLE;
            end
            ST_CALC: begin
                state_s = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (fifo_enough_s) state_s = ST_BURST;
                else               state_s = ST_WAIT_DATA;
            end
            ST_BURST: begin
                if (last_beat_s) state_s = ST_WAIT_IDLE;
                else             state_s = ST_BURST;
            end
            ST_WAIT_IDLE: begin
                if (!dma_ready)                              state_s = ST_WAIT_IDLE;
                else if (remaining_r == {CNT_W{1'b0}})       state_s = ST_IDLE;
                else                                         state_s = ST_CALC;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Job bookkeeping and registered burst outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            valid_r     <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            dma_len_r   <= {LEN_W{1'b0}};
            job_cnt_r   <= {CNT_W{1'b0}};
            in_cnt_r    <= {CNT_W{1'b0}};
            remaining_r <= {CNT_W{1'b0}};
            cur_addr_r  <= {ADDR_W{1'b0}};
            beats_r     <= {BEAT_W{1'b0}};
            beat_cnt_r  <= {BEAT_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            if (push_s) begin
                in_cnt_r <= in_cnt_r + CNT_W'(1);
            end
            case (state_r)
                ST_IDLE: begin
                    if (start && (word_count == {CNT_W{1'b0}})) begin
                        done_r <= 1'b1;
                    end else if (start) begin
                        busy_r      <= 1'b1;
                        job_cnt_r   <= word_count;
                        remaining_r <= word_count;
                        in_cnt_r    <= {CNT_W{1'b0}};
                        cur_addr_r  <= base_addr & ALIGN_MASK;
                    end
                end
                ST_CALC: begin
                    beats_r   <= beats_s;
                    dma_len_r <= LEN_W'(beats_s - BEAT_W'(1));
                    addr_r    <= cur_addr_r;
                end
                ST_WAIT_DATA: begin
                    if (fifo_enough_s) begin
                        valid_r    <= 1'b1;
                        beat_cnt_r <= {BEAT_W{1'b0}};
                    end
                end
                ST_BURST: begin
                    if (ready) begin
                        beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                    end
                    if (last_beat_s) begin
                        valid_r     <= 1'b0;
                        remaining_r <= remaining_r - CNT_W'(beats_r);
                        cur_addr_r  <= cur_addr_r + (ADDR_W'(beats_r) << OFF_W);
                    end
                end
                ST_WAIT_IDLE: begin
                    if (dma_ready && (remaining_r == {CNT_W{1'b0}})) begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign valid   = valid_r;
    assign addr    = addr_r;
    assign dma_len = dma_len_r;
    assign wstrb   = {(DMA_DATA_W/8){1'b1}};

endmodule

// File: doc/dma_w_burst_split.md
Name: dma_w_burst_split

Overview:
- Upstream feeder for the DMA AXI write engine.
- Takes a write job (base address, word count) and a word stream. Buffers the words in an internal FIFO.
- Splits the job into AXI-legal INCR bursts: at most MAX_BURST beats, never crossing a 4 KB boundary.
- Presents each burst to the write engine's databus/config ports (valid, addr, wdata, wstrb, dma_len; ready, dma_ready), one burst at a time.

Parameters:
- DMA_DATA_W, 32, data width in bits (power of 2, >= 8).
- ADDR_W, 32, byte address width.
- LEN_W, 8, AXI burst-length field width.
- FIFO_ADDR_W, 4, log2 of FIFO depth (16 words).
- MAX_BURST, 16, maximum beats per burst. Must be <= 2^FIFO_ADDR_W and <= 2^LEN_W.
- CNT_W, 24, width of the job word count.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, asynchronous, active-high.
- start, input, 1, one-cycle pulse that launches a job.
- base_addr, input, ADDR_W, job start byte address, sampled on start.
- word_count, input, CNT_W, number of words in the job, sampled on start.
- busy, output, 1, high while a job is in progress.
- done, output, 1, one-cycle pulse at job end.
- s_valid, input, 1, stream word valid.
- s_data, input, DMA_DATA_W, stream word.
- s_ready, output, 1, stream word accepted when s_valid && s_ready.
- valid, output, 1, burst request to the write engine.
- addr, output, ADDR_W, burst start byte address.
- wdata, output, DMA_DATA_W, current beat data (FIFO head).
- wstrb, output, DMA_DATA_W/8, byte strobes; always all ones.
- dma_len, output, LEN_W, beats-1 of the current burst.
- ready, input, 1, one-cycle pulse per beat consumed by the write engine.
- dma_ready, input, 1, write engine idle (high only in its address-handshake state).

Behaviour:
- Reset values:
  - State IDLE.
  - Outputs busy=0, done=0, s_ready=0, valid=0, addr=0, dma_len=0; wstrb all ones.
  - FIFO flushed; all counters 0.
  - Reset mid-job aborts the job with no done pulse.
- FIFO:
  - Synchronous, first-word-fall-through; wdata = head word.
  - Push on s_valid && s_ready; pop on ready.
  - A simultaneous push and pop leaves the level unchanged.
  - A pop when empty is a protocol error: ignored, level stays 0.
- Input side:
  - s_ready = busy && !fifo_full && (in_cnt != job_cnt).
  - in_cnt increments per accepted word.
  - Extra stream words beyond word_count are never accepted.
- Address handling:
  - Low log2(DMA_DATA_W/8) bits of base_addr are forced to zero on capture.
  - bytes = DMA_DATA_W/8.
  - to_4k = (4096 - cur_addr[11:0]) / bytes.
- Burst size:
  - beats = min(remaining, MAX_BURST, to_4k), always >= 1 while remaining > 0.
  - dma_len = beats-1, truncated to LEN_W.
- FSM:
  - IDLE:
    - busy=0.
    - start with word_count=0: done pulses the next cycle and the FSM stays in IDLE.
    - start with word_count>0: capture the job; busy=1; remaining=word_count; go to CALC.
    - start while busy is ignored.
  - CALC (1 cycle): register beats, dma_len, addr=cur_addr; go to WAIT_DATA.
  - WAIT_DATA: when fifo_level >= beats, set valid=1 and go to BURST. A burst therefore never starves mid-transfer.
  - BURST:
    - valid held high; a beat counter counts ready pulses.
    - On the ready pulse that completes beats: clear valid on the next edge (registered); remaining -= beats; cur_addr += beats*bytes; go to WAIT_IDLE.
  - WAIT_IDLE: wait until dma_ready==1 (write response complete).
    - If remaining==0: done=1 for one cycle, busy=0, go to IDLE.
    - Otherwise go to CALC.
- Latency: from start, valid rises no earlier than 2 cycles after the FIFO holds beats words.
- Invariants:
  - valid is never high while in WAIT_IDLE, CALC, or IDLE.
  - addr and dma_len are stable while valid=1.
- Address wrap at 2^ADDR_W wraps modulo; no error is flagged.

Test Plan:
- Single burst: base 0x1000, count 4, stream 0xA0..0xA3 → one request with addr=0x1000, dma_len=3; wdata sequence A0..A3 on successive ready pulses; done once; busy low after.
- Multi-burst: base 0x0, count 40, MAX_BURST 16 → bursts at 0x0/len 15, 0x40/len 15, 0x80/len 7; each issued only after dma_ready returns high.
- 4 KB split: base 0xFF8, count 6 → burst 0xFF8/len 1, then 0x1000/len 3.
- Backpressure/starvation: stream word every 3rd cycle, count 16 → valid stays low until the FIFO holds 16 words; no ready gaps are caused by an empty FIFO. With excess s_valid, s_ready drops after 16 words.
- Edge cases: count 0 → done on the next cycle, no valid. start while busy → ignored. Unaligned base 0x1003 → addr 0x1000.
- Reset mid-burst: assert rst after 2 of 8 beats → all outputs at reset values immediately; FIFO empty; no done; a new job then runs normally.
